gate_stim_checker: RTL and testbench
====================================

# gate_stim_checker

Self-checking stimulus sequencer that sits upstream and downstream of the two-input `GATES` block. It drives every `A`/`B` input combination into `GATES` and holds each one for a programmable dwell time. It samples the six gate outputs at the end of each dwell, compares them with the expected truth table, and reports error count, per-vector failure mask, pass/fail and a done pulse. This lets the gate block be checked on hardware or in a bench without a hand-written waveform review.

## Interface
Parameters:
- `DWELL`, default 10: clock cycles each input vector is held. Legal range ≥1; use ≥2 when gate delays are modelled.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: begins a run when sampled high in IDLE.
- `A` output 1: registered stimulus to `GATES.A`.
- `B` output 1: registered stimulus to `GATES.B`.
- `AND`, `OR`, `NAND`, `XOR`, `XNOR`, `NOT` inputs, 1 bit each: observed outputs of `GATES`.
- `busy` output 1: high while a run is in progress.
- `done` output 1: one-cycle pulse at end of a completed run.
- `pass` output 1: high after a completed run with zero mismatches.
- `err_count` output 3: number of failing vectors in last run (0..4).
- `fail_vec` output 4: bit i set if vector i failed; i = {A,B}.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - `A`=`B`=0, `busy`=0.
  - `start`=1 → RUN with index=0 and dwell counter=0.
  - Entering RUN clears `err_count`, `fail_vec` and `pass` to 0.
- RUN:
  - `busy`=1; `A`=index[1], `B`=index[0].
  - Vector order: 00, 01, 10, 11.
  - Dwell counter counts 0..DWELL-1. Counter width is the minimum needed to hold DWELL-1, with a minimum of 1 bit.
  - When counter = DWELL-1 (sample cycle), the six inputs are compared against the expected values:
    - AND = A&B, OR = A|B, NAND = ~(A&B)
    - XOR = A^B, XNOR = ~(A^B), NOT = ~A
  - Any mismatch on the sample cycle: `fail_vec[index]` ← 1 and `err_count` += 1. A vector counts at most once.
  - After the sample cycle, the counter resets to 0 and index increments. After index 3 → FINISH.
- FINISH (one cycle):
  - `done`=1, `busy`=0, `A`=`B`=0.
  - `pass` ← (`err_count`==0 including any vector-3 failure).
  - → IDLE.
- Results (`err_count`, `fail_vec`, `pass`) hold until the next accepted start.
- `start` is ignored in RUN and FINISH. `start` held high in IDLE launches back-to-back runs.
- Inputs are compared only on sample cycles; values at all other times are don't-care.

## Timing
- Reset values: state IDLE, `A`=0, `B`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0000.
- Reset mid-run:
  - Immediate abort to the reset values above.
  - No `done` pulse.
  - Partial results are discarded.
- Start on edge N → `busy`=1 and `A`/`B`=00 visible after edge N.
- Each vector is visible for exactly DWELL cycles. Total `busy` high = 4·DWELL cycles.
- `done` pulses for the one cycle after the last sample edge; `pass` is valid from that same cycle.
- Earliest restart: `start` sampled during the FINISH cycle is ignored. `start` sampled in the following IDLE cycle is accepted.
- `GATES` is combinational. With DWELL=1, the outputs must settle within one clock period of the registered `A`/`B`.

## Test plan
- Correct `GATES`, DWELL=10, 1-cycle start pulse:
  - `busy` high for 40 cycles; `A`/`B` = 00, 01, 10, 11, 10 cycles each.
  - `done` for 1 cycle.
  - `pass`=1, `err_count`=0, `fail_vec`=0000.
- `XOR` forced to 0: vectors 01 and 10 fail → `err_count`=2, `fail_vec`=0110, `pass`=0.
- `NOT` forced to 1, then `NAND` forced to 0 in a second run:
  - Run 1 → `fail_vec`=1100, `err_count`=2.
  - Run 2 → `fail_vec`=0111, `err_count`=3.
  - Confirms results are cleared on start.
- `rst` asserted at cycle 15 of a run: all outputs 0 on the same cycle and no `done`. Next start produces a clean 40-cycle run with `pass`=1.
- `start` pulsed at cycles 5 and 39 of a run is ignored (no extended `busy`). `start` held high continuously gives runs separated by one FINISH and one IDLE cycle.
- DWELL=1: `busy` high for 4 cycles, `A`/`B` change every cycle, `done` on cycle 5, `pass`=1.

Source files
------------

// File: rtl/gate_stim_checker.sv
// Stimulus sequencer and checker for the two-input GATES block: walks A/B through
// 00,01,10,11, holds each for DWELL cycles, and scores the six gate outputs.
module gate_stim_checker #(
  parameter int DWELL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       AND,
  input  logic       OR,
  input  logic       NAND,
  input  logic       XOR,
  input  logic       XNOR,
  input  logic       NOT,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0]    err_q, err_d;
  logic [3:0]    fail_q, fail_d;
  logic [5:0]    exp_vec, obs_vec;
  logic          miss;

  // Expected outputs are derived from the registered stimulus currently on the pins.
  always_comb begin
    exp_vec = {a_q & b_q, a_q | b_q, ~(a_q & b_q), a_q ^ b_q, ~(a_q ^ b_q), ~a_q};
    obs_vec = {AND, OR, NAND, XOR, XNOR, NOT};
    miss    = (obs_vec != exp_vec);
    err_d   = err_q + 3'(miss);
    fail_d  = fail_q | (4'(miss) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
          end
        end
        RUN: begin
          if (cnt_q == LAST) begin
            cnt_q  <= '0;
            err_q  <= err_d;
            fail_q <= fail_d;
            if (idx_q == 2'd3) begin
              // pass must include the verdict of the vector sampled on this edge
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              pass_q  <= (err_d == 3'd0);
            end else begin
              idx_q      <= idx_q + 2'd1;
              {a_q, b_q} <= idx_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: a faultable GATES model feeds two instances (DWELL=10 and 1);
// run results are predicted from the truth table and the injected fault modes.
module tb_gate_stim_checker;
  logic clk = 1'b0, rst = 1'b1, start10 = 1'b0, start1 = 1'b0, sel = 1'b0;
  logic [5:0][1:0] fmode = '0;  // per output {AND,OR,NAND,XOR,XNOR,NOT}: 0 ok, 1 stuck0, 2 stuck1, 3 inverted
  logic a10, b10, busy10, done10, pass10;
  logic a1, b1, busy1, done1, pass1;
  logic [2:0] err10, err1;
  logic [3:0] fv10, fv1;
  logic [5:0] g10, g1;
  logic [3:0] st;
  logic [7:0] res;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] truth(input int a, input int b);
    int s = a + b;
    int p = a * b;
    logic [5:0] r;
    r[5] = (p == 1);
    r[4] = (s > 0);
    r[3] = (p == 0);
    r[2] = (s == 1);
    r[1] = (s != 1);
    r[0] = (a == 0);
    return r;
  endfunction

  function automatic logic [5:0] gate_out(input int a, input int b, input logic [5:0][1:0] m);
    logic [5:0] t = truth(a, b);
    logic [5:0] r;
    for (int i = 0; i < 6; i++)
      case (m[i])
        2'd0: r[i] = t[i];
        2'd1: r[i] = 1'b0;
        2'd2: r[i] = 1'b1;
        default: r[i] = ~t[i];
      endcase
    return r;
  endfunction

  function automatic void ref_results(output logic [3:0] fv, output logic [2:0] ec);
    fv = '0;
    ec = '0;
    for (int v = 0; v < 4; v++)
      if (gate_out(v / 2, v % 2, fmode) != truth(v / 2, v % 2)) begin
        fv[v] = 1'b1;
        ec    = ec + 3'd1;
      end
  endfunction

  assign g10 = gate_out(int'(a10), int'(b10), fmode);
  assign g1  = gate_out(int'(a1), int'(b1), fmode);

  gate_stim_checker #(.DWELL(10)) u_d10 (
    .clk(clk), .rst(rst), .start(start10), .A(a10), .B(b10),
    .AND(g10[5]), .OR(g10[4]), .NAND(g10[3]), .XOR(g10[2]), .XNOR(g10[1]), .NOT(g10[0]),
    .busy(busy10), .done(done10), .pass(pass10), .err_count(err10), .fail_vec(fv10)
  );

  gate_stim_checker #(.DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .AND(g1[5]), .OR(g1[4]), .NAND(g1[3]), .XOR(g1[2]), .XNOR(g1[1]), .NOT(g1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  always_comb begin
    st  = sel ? {busy1, done1, a1, b1} : {busy10, done10, a10, b10};
    res = sel ? {pass1, err1, fv1} : {pass10, err10, fv10};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else start10 = v;
  endtask

  // One full run from IDLE (or from an IDLE cycle that already sees start when launched=1).
  task automatic run(input bit s, input bit hold, input bit poke, input bit launched);
    int d = s ? 1 : 10;
    logic [3:0] fv;
    logic [2:0] ec;
    sel = s;
    ref_results(fv, ec);
    if (!launched) set_start(1'b1);
    tick;
    if (!hold) set_start(1'b0);
    for (int k = 0; k < 4 * d; k++) begin
      chk("run_stat", 32'(st), 32'({2'b10, 2'(k / d)}));
      if (k == 0) chk("clr_on_start", 32'(res), 32'd0);
      if (poke && (k == 5 || k == 4 * d - 1)) set_start(1'b1);
      tick;
      if (!hold) set_start(1'b0);
    end
    chk("fin_stat", 32'(st), 32'b0100);
    chk("fin_res", 32'(res), 32'({ec == 3'd0, ec, fv}));
    tick;
    chk("idle_stat", 32'(st), 32'd0);
    chk("hold_res", 32'(res), 32'({ec == 3'd0, ec, fv}));
  endtask

  initial begin
    bit s;
    repeat (3) tick;
    chk("rst10", 32'({busy10, done10, a10, b10, pass10, err10, fv10}), 32'd0);
    chk("rst1", 32'({busy1, done1, a1, b1, pass1, err1, fv1}), 32'd0);
    rst = 1'b0;
    tick;

    fmode = '0;
    run(0, 0, 0, 0);
    chk("good_pass", 32'({pass10, err10, fv10}), 32'h80);

    fmode = '0; fmode[2] = 2'd1;
    run(0, 0, 0, 0);
    chk("xor_fv", 32'(fv10), 32'b0110);
    chk("xor_ec", 32'(err10), 32'd2);

    fmode = '0; fmode[0] = 2'd2;
    run(0, 0, 0, 0);
    chk("not_fv", 32'(fv10), 32'b1100);

    fmode = '0; fmode[3] = 2'd1;
    run(0, 0, 0, 0);
    chk("nand_fv", 32'(fv10), 32'b0111);
    chk("nand_ec", 32'(err10), 32'd3);

    sel = 1'b0;
    start10 = 1'b1;
    tick;
    start10 = 1'b0;
    repeat (15) tick;
    rst = 1'b1;
    #1;
    chk("rst_mid", 32'({busy10, done10, a10, b10, pass10, err10, fv10}), 32'd0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk("no_done_after_rst", 32'({busy10, done10}), 32'd0);
      tick;
    end

    fmode = '0;
    run(0, 0, 1, 0);
    run(0, 1, 0, 0);
    run(0, 1, 0, 1);
    run(0, 0, 0, 1);

    run(1, 0, 0, 0);
    fmode[2] = 2'd1;
    run(1, 0, 0, 0);
    chk("d1_xor_fv", 32'(fv1), 32'b0110);

    repeat (24) begin
      for (int i = 0; i < 6; i++)
        fmode[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      s = 1'($urandom_range(0, 1));
      run(s, 0, !s && ($urandom_range(0, 1) == 1), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
